// File: rtl/rvfi_retire_fifo.sv
// Buffers RVFI retirement packets for a downstream consumer, counting dropped packets on overflow.
// Define RVFI_ORDER_CHECK_EN to build the retirement-order checker (order_err tied 0 otherwise).
module rvfi_retire_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rvfi_valid,
  input  logic          rvfi_trap,
  input  logic [63:0]   rvfi_order,
  input  logic [31:0]   rvfi_insn,
  input  logic [31:0]   rvfi_pc_rdata,
  input  logic [31:0]   rvfi_pc_wdata,
  input  logic [31:0]   rvfi_rd_wdata,
  input  logic [4:0]    rvfi_rd_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_order,
  output logic [31:0]   out_insn,
  output logic [31:0]   out_pc_rdata,
  output logic [31:0]   out_pc_wdata,
  output logic [31:0]   out_rd_wdata,
  output logic [4:0]    out_rd_addr,
  output logic          out_trap,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic [15:0]   drop_count,
  output logic          order_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] insn;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] rd_wdata;
    logic [4:0]  rd_addr;
    logic        trap;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          wr_entry;
  entry_t          head;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q;
  logic [15:0]     drop_count_q;
  logic            push, pop, drop;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts a packet when the head leaves in the same cycle.
  assign push      = rvfi_valid & ((count_q < DepthC) | pop);
  assign drop      = rvfi_valid & ~push;

  always_comb begin
    wr_entry          = '0;
    wr_entry.order    = rvfi_order;
    wr_entry.insn     = rvfi_insn;
    wr_entry.pc_rdata = rvfi_pc_rdata;
    wr_entry.pc_wdata = rvfi_pc_wdata;
    wr_entry.rd_wdata = (rvfi_rd_addr == 5'd0) ? 32'd0 : rvfi_rd_wdata;
    wr_entry.rd_addr  = rvfi_rd_addr;
    wr_entry.trap     = rvfi_trap;
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
      end
    end
  end

  // Gate the head so outputs read zero whenever nothing is buffered (including in reset).
  assign head         = out_valid ? mem[rd_ptr_q] : '0;
  assign out_order    = head.order;
  assign out_insn     = head.insn;
  assign out_pc_rdata = head.pc_rdata;
  assign out_pc_wdata = head.pc_wdata;
  assign out_rd_wdata = head.rd_wdata;
  assign out_rd_addr  = head.rd_addr;
  assign out_trap     = head.trap;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign drop_count   = drop_count_q;

`ifdef RVFI_ORDER_CHECK_EN
  typedef enum logic [0:0] {StIdle, StTrack} chk_state_e;

  chk_state_e  state_q, state_d;
  logic [63:0] expected_q, expected_d;
  logic        order_err_q, order_err_d;

  // Dropped packets are checked too: the core's order stream is judged, not the FIFO contents.
  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    order_err_d = order_err_q;
    unique case (state_q)
      StIdle: begin
        if (rvfi_valid) begin
          state_d    = StTrack;
          expected_d = rvfi_order + 64'd1;
        end
      end
      StTrack: begin
        if (rvfi_valid) begin
          if (rvfi_order != expected_q) order_err_d = 1'b1;
          expected_d = rvfi_order + 64'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      expected_q  <= '0;
      order_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      order_err_q <= order_err_d;
    end
  end

  assign order_err = order_err_q;
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_retire_fifo.sv
// Self-checking bench for rvfi_retire_fifo: directed scenarios plus random traffic against a
// queue-based reference model. Honours RVFI_ORDER_CHECK_EN the same way the design does.
module tb_rvfi_retire_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          rvfi_valid, rvfi_trap, out_ready;
  logic [63:0]   rvfi_order;
  logic [31:0]   rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rd_wdata;
  logic [4:0]    rvfi_rd_addr;
  logic          out_valid, out_trap, overflow, order_err;
  logic [63:0]   out_order;
  logic [31:0]   out_insn, out_pc_rdata, out_pc_wdata, out_rd_wdata;
  logic [4:0]    out_rd_addr;
  logic [CW-1:0] count;
  logic [15:0]   drop_count;

  rvfi_retire_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clock         (clock),
    .reset         (reset),
    .rvfi_valid    (rvfi_valid),
    .rvfi_trap     (rvfi_trap),
    .rvfi_order    (rvfi_order),
    .rvfi_insn     (rvfi_insn),
    .rvfi_pc_rdata (rvfi_pc_rdata),
    .rvfi_pc_wdata (rvfi_pc_wdata),
    .rvfi_rd_wdata (rvfi_rd_wdata),
    .rvfi_rd_addr  (rvfi_rd_addr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_order     (out_order),
    .out_insn      (out_insn),
    .out_pc_rdata  (out_pc_rdata),
    .out_pc_wdata  (out_pc_wdata),
    .out_rd_wdata  (out_rd_wdata),
    .out_rd_addr   (out_rd_addr),
    .out_trap      (out_trap),
    .count         (count),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .order_err     (order_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] order;
    logic [31:0] insn, pc_rdata, pc_wdata, rd_wdata;
    logic [4:0]  rd_addr;
    logic        trap;
  } pkt_t;

  pkt_t        mq[$];
  bit          m_overflow, m_order_err, m_tracking;
  int          m_drops;
  logic [63:0] m_expected;
  int          n_checks = 0;
  int          n_errors = 0;
`ifdef RVFI_ORDER_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_overflow  = 1'b0;
    m_order_err = 1'b0;
    m_tracking  = 1'b0;
    m_drops     = 0;
    m_expected  = '0;
  endtask

  // Applies the rules to the inputs the DUT just sampled on this rising edge.
  task automatic model_update();
    pkt_t p;
    bit   do_pop, do_push;
    do_pop  = (mq.size() != 0) && out_ready;
    do_push = rvfi_valid && ((mq.size() < DEPTH) || do_pop);
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      p.order    = rvfi_order;
      p.insn     = rvfi_insn;
      p.pc_rdata = rvfi_pc_rdata;
      p.pc_wdata = rvfi_pc_wdata;
      p.rd_wdata = (rvfi_rd_addr == 0) ? 32'd0 : rvfi_rd_wdata;
      p.rd_addr  = rvfi_rd_addr;
      p.trap     = rvfi_trap;
      mq.push_back(p);
    end
    if (rvfi_valid && !do_push) begin
      m_overflow = 1'b1;
      if (m_drops < 65535) m_drops++;
    end
    if (CheckEn && rvfi_valid) begin
      if (m_tracking && rvfi_order != m_expected) m_order_err = 1'b1;
      m_tracking = 1'b1;
      m_expected = rvfi_order + 64'd1;
    end
  endtask

  task automatic check_all();
    check("out_valid", out_valid, (mq.size() != 0));
    check("count", count, mq.size());
    check("overflow", overflow, m_overflow);
    check("drop_count", drop_count, m_drops);
    check("order_err", order_err, m_order_err);
    if (mq.size() != 0) begin
      check("out_order", out_order, mq[0].order);
      check("out_insn", out_insn, mq[0].insn);
      check("out_pc_rdata", out_pc_rdata, mq[0].pc_rdata);
      check("out_pc_wdata", out_pc_wdata, mq[0].pc_wdata);
      check("out_rd_wdata", out_rd_wdata, mq[0].rd_wdata);
      check("out_rd_addr", out_rd_addr, mq[0].rd_addr);
      check("out_trap", out_trap, mq[0].trap);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_update();
    @(negedge clock);
    check_all();
  endtask

  task automatic drive(input bit v, input logic [63:0] ord, input bit rdy,
                       input logic [4:0] rd, input logic [31:0] wd);
    rvfi_valid    = v;
    rvfi_order    = ord;
    out_ready     = rdy;
    rvfi_rd_addr  = rd;
    rvfi_rd_wdata = wd;
    rvfi_insn     = $urandom;
    rvfi_pc_rdata = $urandom;
    rvfi_pc_wdata = $urandom;
    rvfi_trap     = 1'($urandom_range(0, 1));
    cycle();
  endtask

  // Called on a falling edge; reset is asserted between edges to observe its asynchronous effect.
  task automatic do_reset();
    rvfi_valid = 1'b0;
    out_ready  = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_order_err", order_err, 0);
    check("rst_out_order", out_order, 0);
    check("rst_out_rd_wdata", out_rd_wdata, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic [63:0] next_ord;
    logic [63:0] ord;
    bit          v;
    reset         = 1'b1;
    rvfi_valid    = 1'b0;
    rvfi_trap     = 1'b0;
    rvfi_order    = '0;
    rvfi_insn     = '0;
    rvfi_pc_rdata = '0;
    rvfi_pc_wdata = '0;
    rvfi_rd_wdata = '0;
    rvfi_rd_addr  = '0;
    out_ready     = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_all();

    // In-order stream, consumer always ready: head visible one cycle after each push.
    drive(1, 0, 1, 5'd1, 32'h11);
    check("first_valid", out_valid, 1);
    check("first_order", out_order, 0);
    for (int i = 1; i < 4; i++) drive(1, i, 1, 5'(i + 1), $urandom);
    drive(0, 0, 1, 0, 0);
    check("stream_err", order_err, 0);

    // Overfill with consumer stalled, then drain.
    do_reset();
    for (int i = 0; i < 10; i++) drive(1, i, 0, 5'd3, $urandom);
    check("full_count", count, 8);
    check("full_overflow", overflow, 1);
    check("full_drops", drop_count, 2);
    for (int i = 0; i < 9; i++) drive(0, 0, 1, 0, 0);
    check("drained", count, 0);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 8; i++) drive(1, i, 0, 5'd4, $urandom);
    drive(1, 8, 1, 5'd4, 32'h1234);
    check("pp_count", count, 8);
    check("pp_overflow", overflow, 0);
    check("pp_head", out_order, 1);
    for (int i = 0; i < 8; i++) drive(0, 0, 1, 0, 0);

    // Order gap 5,6,8.
    do_reset();
    drive(1, 5, 1, 5'd2, $urandom);
    drive(1, 6, 1, 5'd2, $urandom);
    check("gap_before", order_err, 0);
    drive(1, 8, 1, 5'd2, $urandom);
    check("gap_err", order_err, CheckEn);
    drive(1, 9, 1, 5'd2, $urandom);
    drive(0, 0, 1, 0, 0);
    check("gap_sticky", order_err, CheckEn);

    // x0 destination never carries write data.
    do_reset();
    drive(1, 0, 0, 5'd0, 32'hDEADBEEF);
    check("x0_wdata", out_rd_wdata, 0);
    drive(0, 0, 1, 0, 0);

    // Reset with entries buffered, then restart at an arbitrary order.
    do_reset();
    for (int i = 0; i < 5; i++) drive(1, i, 0, 5'd7, $urandom);
    check("pre_rst_count", count, 5);
    do_reset();
    drive(1, 100, 1, 5'd6, $urandom);
    drive(1, 101, 1, 5'd6, $urandom);
    check("restart_err", order_err, 0);
    drive(0, 0, 1, 0, 0);

    // Random traffic.
    do_reset();
    next_ord = 64'd40;
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 9) < 7);
      ord = next_ord;
      if ($urandom_range(0, 59) == 0) ord = {$urandom, $urandom};
      if (v) next_ord = ord + 64'd1;
      drive(v, ord, ($urandom_range(0, 9) < 5),
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
